// File: rtl/icc_branch_unit.sv
// Integer condition-code register with Bicc condition evaluation, same-cycle EX flag bypass,
// and the delay-slot / annul sequencer for branches sitting in ID.
module icc_branch_unit #(
  parameter logic [3:0] ICC_RST   = 4'b0000,
  parameter bit         DCTI_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Z_EX,
  input  logic       N_EX,
  input  logic       C_EX,
  input  logic       V_EX,
  input  logic       CC_WE,
  input  logic       stall,
  input  logic       br_id,
  input  logic [3:0] cond,
  input  logic       a_bit,
  output logic [3:0] icc,
  output logic       Ci,
  output logic       br_taken,
  output logic       annul_slot,
  output logic       dcti_err
);

  typedef enum logic [1:0] {IDLE, SLOT, ANNUL} state_t;

  state_t     state;
  logic [3:0] flags_ex;
  logic [3:0] eval_flags;
  logic       cond_true;
  logic       slot_trap;
  logic       annul_cond;

  // Upper half of the cond encoding is the bitwise complement of the lower half; BN/BA share 000.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy, base;
    n  = f[3];
    z  = f[2];
    v  = f[1];
    cy = f[0];
    case (c[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = cy | z;
      3'b101:  base = cy;
      3'b110:  base = n;
      default: base = v;
    endcase
    return base ^ c[3];
  endfunction

  assign flags_ex   = {N_EX, Z_EX, V_EX, C_EX};
  assign eval_flags = CC_WE ? flags_ex : icc;
  assign cond_true  = cond_eval(cond, eval_flags);
  assign slot_trap  = (state == SLOT) && DCTI_TRAP;
  // A branch in an annulled slot is squashed, so it never redirects fetch.
  assign br_taken   = br_id & cond_true & ~slot_trap & (state != ANNUL);
  assign annul_cond = a_bit & (~cond_true | (cond == 4'b1000));
  assign Ci         = icc[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      icc        <= ICC_RST;
      state      <= IDLE;
      annul_slot <= 1'b0;
      dcti_err   <= 1'b0;
    end else if (!stall) begin
      if (CC_WE) icc <= flags_ex;
      case (state)
        IDLE: begin
          if (br_id && annul_cond) begin
            state      <= ANNUL;
            annul_slot <= 1'b1;
          end else if (br_id) begin
            state      <= SLOT;
          end
        end
        // SLOT: a nested branch is a DCTI fault; any other slot instruction simply retires.
        SLOT: begin
          state      <= IDLE;
          annul_slot <= 1'b0;
          if (br_id && DCTI_TRAP) dcti_err <= 1'b1;
        end
        ANNUL: begin
          state      <= IDLE;
          annul_slot <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          annul_slot <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icc_branch_unit.sv
// Bench for icc_branch_unit: condition sweep via vector table and scoreboard,
// plus directed sequences for bypass, annul, stall, delay-slot fault and reset.
module tb_icc_branch_unit;

  logic       clk = 1'b0;
  logic       reset, Z_EX, N_EX, C_EX, V_EX, CC_WE, stall, br_id, a_bit;
  logic [3:0] cond;
  logic [3:0] icc;
  logic       Ci, br_taken, annul_slot, dcti_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] flags;
    logic       exp;
  } vec_t;

  vec_t vecs[256];
  logic exp_q[$];

  icc_branch_unit #(.ICC_RST(4'b0000), .DCTI_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .Z_EX(Z_EX), .N_EX(N_EX), .C_EX(C_EX), .V_EX(V_EX),
    .CC_WE(CC_WE), .stall(stall), .br_id(br_id), .cond(cond), .a_bit(a_bit),
    .icc(icc), .Ci(Ci), .br_taken(br_taken), .annul_slot(annul_slot), .dcti_err(dcti_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference Bicc table, written out entry by entry.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
    case (c)
      4'd0:    return 1'b0;
      4'd1:    return z;
      4'd2:    return z | (n ^ v);
      4'd3:    return n ^ v;
      4'd4:    return cy | z;
      4'd5:    return cy;
      4'd6:    return n;
      4'd7:    return v;
      4'd8:    return 1'b1;
      4'd9:    return !z;
      4'd10:   return !(z | (n ^ v));
      4'd11:   return n == v;
      4'd12:   return !(cy | z);
      4'd13:   return !cy;
      4'd14:   return !n;
      default: return !v;
    endcase
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    {Z_EX, N_EX, C_EX, V_EX, CC_WE, stall, br_id, a_bit} = '0;
    cond = 4'd0;
  endtask

  // Drive point: just after the rising edge; checks happen at the following falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    {N_EX, Z_EX, V_EX, C_EX} = f;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      vecs[i].cond  = i[7:4];
      vecs[i].flags = i[3:0];
      vecs[i].exp   = ref_cond(i[7:4], i[3:0]);
    end

    // T1: reset
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_icc", icc, 4'b0000);
    check("rst_annul", {3'b0, annul_slot}, 4'd0);
    check("rst_dcti", {3'b0, dcti_err}, 4'd0);
    check("rst_ci", {3'b0, Ci}, 4'd0);
    step();
    reset = 1'b0;

    // T2: bypass of same-cycle flags, then icc visible next cycle
    step();
    CC_WE = 1'b1; set_flags(4'b0101); br_id = 1'b1; cond = 4'b0001;
    @(negedge clk);
    check("t2_bypass_taken", {3'b0, br_taken}, 4'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("t2_icc", icc, 4'b0101);
    check("t2_ci", {3'b0, Ci}, 4'd1);
    check("t2_no_annul", {3'b0, annul_slot}, 4'd0);

    // T3: branches on stored icc = 1000
    step();
    CC_WE = 1'b1; set_flags(4'b1000);
    step();
    idle_inputs();
    stall = 1'b1; br_id = 1'b1; cond = 4'b0011;
    @(negedge clk);
    check("t3_icc", icc, 4'b1000);
    check("t3_bl", {3'b0, br_taken}, 4'd1);
    step();
    cond = 4'b1011;
    @(negedge clk);
    check("t3_bge", {3'b0, br_taken}, 4'd0);

    // T3 sweep: all conds x flag values through the bypass path, held by stall
    foreach (vecs[i]) begin
      step();
      stall = 1'b1; CC_WE = 1'b1; br_id = 1'b1; a_bit = 1'b0;
      set_flags(vecs[i].flags);
      cond = vecs[i].cond;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sweep_queue: scoreboard empty at vector %0d", i);
      end else begin
        check($sformatf("sweep_c%0d_f%0d", vecs[i].cond, vecs[i].flags),
              {3'b0, br_taken}, {3'b0, exp_q.pop_front()});
      end
    end
    step();
    idle_inputs();
    @(negedge clk);
    check("sweep_icc_held", icc, 4'b1000);
    check("sweep_state_held", {3'b0, annul_slot}, 4'd0);

    // T4: BA,a annuls the slot for exactly one cycle
    step();
    br_id = 1'b1; cond = 4'b1000; a_bit = 1'b1;
    @(negedge clk);
    check("t4_ba_taken", {3'b0, br_taken}, 4'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("t4_annul_on", {3'b0, annul_slot}, 4'd1);
    step();
    @(negedge clk);
    check("t4_annul_off", {3'b0, annul_slot}, 4'd0);

    // T5: BNE,a with Z=1 is untaken and annuls; annul holds across stall
    step();
    CC_WE = 1'b1; set_flags(4'b0100);
    step();
    idle_inputs();
    br_id = 1'b1; cond = 4'b1001; a_bit = 1'b1;
    @(negedge clk);
    check("t5_bne_not_taken", {3'b0, br_taken}, 4'd0);
    step();
    idle_inputs();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t5_stall_annul%0d", k), {3'b0, annul_slot}, 4'd1);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check("t5_annul_still_before_edge", {3'b0, annul_slot}, 4'd1);
    step();
    @(negedge clk);
    check("t5_annul_dropped", {3'b0, annul_slot}, 4'd0);

    // BE,a taken (Z=1): slot executes, no annul
    step();
    br_id = 1'b1; cond = 4'b0001; a_bit = 1'b1;
    @(negedge clk);
    check("bea_taken", {3'b0, br_taken}, 4'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check("bea_no_annul", {3'b0, annul_slot}, 4'd0);
    step();

    // BN,a: not taken, slot annulled
    br_id = 1'b1; cond = 4'b0000; a_bit = 1'b1;
    @(negedge clk);
    check("bna_not_taken", {3'b0, br_taken}, 4'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("bna_annul", {3'b0, annul_slot}, 4'd1);
    step();

    // T6: branch in delay slot is forced untaken and sets sticky dcti_err
    br_id = 1'b1; cond = 4'b0001; a_bit = 1'b0;
    @(negedge clk);
    check("t6_be_taken", {3'b0, br_taken}, 4'd1);
    step();
    br_id = 1'b1; cond = 4'b1000; a_bit = 1'b0;
    @(negedge clk);
    check("t6_slot_branch_forced", {3'b0, br_taken}, 4'd0);
    check("t6_dcti_not_yet", {3'b0, dcti_err}, 4'd0);
    step();
    idle_inputs();
    @(negedge clk);
    check("t6_dcti_set", {3'b0, dcti_err}, 4'd1);
    step();
    step();
    @(negedge clk);
    check("t6_dcti_sticky", {3'b0, dcti_err}, 4'd1);

    // Reset while in ANNUL returns to IDLE and clears everything
    step();
    br_id = 1'b1; cond = 4'b1000; a_bit = 1'b1;
    step();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("t6_annul_before_rst", {3'b0, annul_slot}, 4'd1);
    step();
    @(negedge clk);
    check("t6_rst_annul", {3'b0, annul_slot}, 4'd0);
    check("t6_rst_dcti", {3'b0, dcti_err}, 4'd0);
    check("t6_rst_icc", icc, 4'b0000);
    step();
    reset = 1'b0;
    br_id = 1'b1; cond = 4'b1000; a_bit = 1'b0;
    @(negedge clk);
    check("t6_idle_after_rst", {3'b0, br_taken}, 4'd1);
    step();
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
